// File: rtl/fetch_prefetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_prefetch_ctrl_pkg;

   localparam int ADDR_W     = 32;
   localparam int INSTR_W    = 32;
   localparam int WORD_BYTES = 4;
   localparam int ENTRY_W    = ADDR_W + INSTR_W;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hE000_0000;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] addr,
                                                  input int unsigned         mem_bytes);
      return addr % ADDR_W'(mem_bytes);
   endfunction

endpackage

// File: rtl/fetch_prefetch_ctrl_fifo.sv
// Generic synchronous FIFO with push/pop/flush; flush wins over push but a pop still completes.
module prefetch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [W-1:0]             i_wdata,
   output logic [W-1:0]             o_rdata,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_full;
   logic          w_do_pop;
   logic          w_do_push;

   assign o_empty   = (r_count == '0);
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!w_full || w_do_pop) && !i_flush;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is not reset; validity is carried entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, gates pushes into the prefetch FIFO and handles redirects.
module fetch_prefetch_ctrl
   import fetch_prefetch_ctrl_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter int unsigned MEM_BYTES = 256,
   parameter int unsigned RESET_PC  = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      fetch_en,
   input  logic                      branch_taken,
   input  logic [ADDR_W-1:0]         branch_addr,
   output logic [ADDR_W-1:0]         imem_addr,
   input  logic [INSTR_W-1:0]        imem_instr,
   output logic                      instr_valid,
   input  logic                      instr_ready,
   output logic [INSTR_W-1:0]        instr_out,
   output logic [ADDR_W-1:0]         pc_out,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      fetching
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] w_next_pc;
   logic              w_run;
   logic              w_push;
   logic              w_pop;
   logic              w_empty;
   logic [CW-1:0]     w_count;
   logic [ADDR_W-1:0] w_target;
   fetch_entry_t      w_wentry;
   fetch_entry_t      w_head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_BOOT;
      else     r_state <= w_next_state;
   end

   // A redirect freezes RUN/HALT for that cycle; BOOT always leaves after one cycle.
   always_comb begin
      // NOTE: default first so no path leaves the signal unassigned and infers a latch.
      w_next_state = r_state;
      case (r_state)
         ST_BOOT: w_next_state = fetch_en ? ST_RUN : ST_HALT;
         ST_RUN:  if (!branch_taken && !fetch_en) w_next_state = ST_HALT;
         ST_HALT: if (!branch_taken &&  fetch_en) w_next_state = ST_RUN;
         default: w_next_state = ST_BOOT;
      endcase
   end

   always_comb begin
      w_run = (r_state == ST_RUN);
   end

   assign w_pop    = !w_empty && instr_ready;
   assign w_push   = w_run && !branch_taken && ((w_count < CW'(DEPTH)) || w_pop);
   assign w_target = {branch_addr[ADDR_W-1:2], 2'b00};

   always_comb begin
      w_next_pc = r_fetch_pc;
      if (branch_taken)
         w_next_pc = wrap_addr(w_target, MEM_BYTES);
      else if (w_push)
         w_next_pc = wrap_addr(r_fetch_pc + ADDR_W'(WORD_BYTES), MEM_BYTES);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_fetch_pc <= ADDR_W'(RESET_PC);
      else     r_fetch_pc <= w_next_pc;
   end

   // The stored PC is fetch address + 4 without wrapping, as decode expects.
   assign w_wentry.pc    = r_fetch_pc + ADDR_W'(WORD_BYTES);
   assign w_wentry.instr = imem_instr;

   prefetch_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (branch_taken),
      .i_wdata (w_wentry),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   assign imem_addr   = r_fetch_pc;
   assign instr_valid = !w_empty;
   assign instr_out   = w_empty ? '0 : w_head.instr;
   assign pc_out      = w_empty ? '0 : w_head.pc;
   assign fifo_count  = w_count;
   assign fetching    = w_push;

endmodule

// File: tb/tb_fetch_prefetch_ctrl.sv
// Directed bench for fetch_prefetch_ctrl with a popped-on-handshake scoreboard.
module tb_fetch_prefetch_ctrl;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_en = 1'b1;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_addr = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic [2:0]  fifo_count;
   logic        fetching;

   logic [31:0] mem [64];
   exp_t        sb [$];
   int          checks = 0;
   int          errors = 0;
   int          pops   = 0;

   fetch_prefetch_ctrl #(
      .DEPTH     (4),
      .MEM_BYTES (256),
      .RESET_PC  (0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .fetch_en     (fetch_en),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_addr    (imem_addr),
      .imem_instr   (imem_instr),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_out    (instr_out),
      .pc_out       (pc_out),
      .fifo_count   (fifo_count),
      .fetching     (fetching)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'(i);
   end
   assign imem_instr = mem[imem_addr[7:2]];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected head sequence for n fetches starting at byte address addr (memory word = index).
   task automatic expect_seq(input logic [31:0] start, input int n);
      logic [31:0] a;
      a = start;
      for (int i = 0; i < n; i++) begin
         sb.push_back('{pc: a + 32'd4, instr: a >> 2});
         a = (a + 32'd4) % 32'd256;
      end
   endtask

   task automatic run_until_drained(input string tag, input int max_cycles, input int exp_cycles);
      int n;
      n = 0;
      while (sb.size() != 0 && n < max_cycles) begin
         tick();
         n++;
      end
      instr_ready = 1'b0;
      check({tag, "_drained"}, 64'(sb.size()), 64'd0);
      check({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      branch_taken = 1'b0;
      sb.delete();
      #2;
      check("rst_valid", 64'(instr_valid), 64'd0);
      check("rst_count", 64'(fifo_count), 64'd0);
      check("rst_imem_addr", 64'(imem_addr), 64'd0);
      check("rst_fetching", 64'(fetching), 64'd0);
      tick();
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready) begin
         exp_t e;
         pops++;
         check("pop_has_expectation", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("pop_pc", 64'(pc_out), 64'(e.pc));
            check("pop_instr", 64'(instr_out), 64'(e.instr));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int p0;

      // Free run after reset: one pop per cycle once BOOT and the first push are done.
      instr_ready = 1'b1;
      do_reset();
      check("boot_no_fetch", 64'(fetching), 64'd0);
      check("boot_instr_out", 64'(instr_out), 64'd0);
      check("boot_pc_out", 64'(pc_out), 64'd0);
      expect_seq(32'h0, 12);
      run_until_drained("free_run", 40, 14);

      // Back-pressure: FIFO saturates, fetch address freezes, release drains back-to-back.
      instr_ready = 1'b0;
      do_reset();
      repeat (10) tick();
      check("full_count", 64'(fifo_count), 64'd4);
      check("full_imem_addr", 64'(imem_addr), 64'd16);
      check("full_no_fetch", 64'(fetching), 64'd0);
      expect_seq(32'h0, 5);
      instr_ready = 1'b1;
      run_until_drained("full_release", 20, 5);

      // Branch with 3 entries queued; the handshake in the branch cycle is delivered once.
      do_reset();
      repeat (4) tick();
      check("pre_branch_count", 64'(fifo_count), 64'd3);
      p0 = pops;
      expect_seq(32'h0, 1);
      branch_addr  = 32'h0000_004B;
      branch_taken = 1'b1;
      instr_ready  = 1'b1;
      tick();
      branch_taken = 1'b0;
      instr_ready  = 1'b0;
      check("branch_flush_count", 64'(fifo_count), 64'd0);
      check("branch_flush_valid", 64'(instr_valid), 64'd0);
      check("branch_imem_addr", 64'(imem_addr), 64'h48);
      check("branch_accept_once", 64'(pops - p0), 64'd1);
      tick();
      check("branch_head_pc", 64'(pc_out), 64'h4C);
      check("branch_head_instr", 64'(instr_out), 64'h12);
      expect_seq(32'h48, 3);
      instr_ready = 1'b1;
      run_until_drained("branch_target", 20, 3);

      // Wrap: fetch at 0xFC is followed by fetch address 0.
      branch_addr  = 32'h0000_00FC;
      branch_taken = 1'b1;
      tick();
      branch_taken = 1'b0;
      check("wrap_imem_addr", 64'(imem_addr), 64'hFC);
      check("wrap_flush_count", 64'(fifo_count), 64'd0);
      expect_seq(32'hFC, 3);
      instr_ready = 1'b1;
      run_until_drained("wrap", 20, 4);

      // fetch_en low: queued entries drain, address holds, then fetch resumes from it.
      do_reset();
      tick();
      tick();
      fetch_en = 1'b0;
      tick();
      check("halt_count", 64'(fifo_count), 64'd2);
      check("halt_imem_addr", 64'(imem_addr), 64'd8);
      check("halt_no_fetch", 64'(fetching), 64'd0);
      expect_seq(32'h0, 2);
      instr_ready = 1'b1;
      run_until_drained("halt_drain", 20, 2);
      check("halt_valid_drop", 64'(instr_valid), 64'd0);
      repeat (2) tick();
      check("halt_addr_hold", 64'(imem_addr), 64'd8);
      check("halt_count_zero", 64'(fifo_count), 64'd0);
      expect_seq(32'h8, 3);
      fetch_en    = 1'b1;
      instr_ready = 1'b1;
      run_until_drained("resume", 20, 5);

      // Asynchronous reset mid-cycle while full.
      repeat (6) tick();
      check("prerst_count", 64'(fifo_count), 64'd4);
      #3;
      rst = 1'b1;
      sb.delete();
      #1;
      check("async_valid", 64'(instr_valid), 64'd0);
      check("async_instr_out", 64'(instr_out), 64'd0);
      check("async_pc_out", 64'(pc_out), 64'd0);
      check("async_count", 64'(fifo_count), 64'd0);
      check("async_imem_addr", 64'(imem_addr), 64'd0);
      tick();
      rst = 1'b0;
      check("async_boot_no_fetch", 64'(fetching), 64'd0);
      tick();
      check("async_first_fetch", 64'(fetching), 64'd1);
      check("async_first_addr", 64'(imem_addr), 64'd0);
      tick();
      check("async_head_pc", 64'(pc_out), 64'd4);
      check("async_head_instr", 64'(instr_out), 64'd0);
      check("async_head_count", 64'(fifo_count), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
